// File: rtl/tone_scheduler_if.sv
// Request/response bundle between the game controller and the tone scheduler.
interface tone_scheduler_if;
  logic       COLOR_REQ;
  logic [1:0] COLOR;
  logic       EVT_REQ;
  logic [1:0] EVT;
  logic       MUTE;
  logic       SPK;
  logic       BUSY;
  logic       DONE;

  modport master (output COLOR_REQ, COLOR, EVT_REQ, EVT, MUTE,
                  input  SPK, BUSY, DONE);
  modport slave  (input  COLOR_REQ, COLOR, EVT_REQ, EVT, MUTE,
                  output SPK, BUSY, DONE);
endinterface

// File: rtl/tone_scheduler.sv
// Piezo arbiter: color tones and 3-note event melodies with priority preemption,
// note/gap timing and a square-wave divider.
module tone_scheduler #(
  parameter logic [15:0] HP0      = 16'd4000,
  parameter logic [15:0] HP1      = 16'd3000,
  parameter logic [15:0] HP2      = 16'd2400,
  parameter logic [15:0] HP3      = 16'd2000,
  parameter logic [23:0] TONE_LEN = 24'd3000000,
  parameter logic [23:0] NOTE_LEN = 24'd1500000,
  parameter logic [23:0] GAP_LEN  = 24'd300000
) (
  input logic CLK,
  input logic RST_N,
  tone_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TONE, NOTE, GAP} state_t;

  state_t      state;
  logic [15:0] hp_cnt, hp_cur;
  logic [23:0] dur;
  logic [1:0]  evt_q, idx;
  logic        tog, done;

  function automatic logic [1:0] rom(input logic [1:0] e, input logic [1:0] i);
    logic [1:0] n;
    case ({e, i})
      4'b00_00: n = 2'd0; 4'b00_01: n = 2'd1; 4'b00_10: n = 2'd2;
      4'b01_00: n = 2'd2; 4'b01_01: n = 2'd3; 4'b01_10: n = 2'd3;
      4'b10_00: n = 2'd0; 4'b10_01: n = 2'd2; 4'b10_10: n = 2'd3;
      4'b11_00: n = 2'd3; 4'b11_01: n = 2'd1; 4'b11_10: n = 2'd0;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] hp_of(input logic [1:0] n);
    case (n)
      2'd0:    return HP0;
      2'd1:    return HP1;
      2'd2:    return HP2;
      default: return HP3;
    endcase
  endfunction

  logic [15:0] start_hp, next_hp;
  logic        evt_ok;

  assign start_hp = hp_of(rom(bus.EVT, 2'd0));
  assign next_hp  = hp_of(rom(evt_q, idx + 2'd1));
  // Events preempt tones always, and melodies only from an equal or higher class.
  assign evt_ok   = bus.EVT_REQ &&
                    (state == IDLE || state == TONE || bus.EVT[1] >= evt_q[1]);

  assign bus.SPK  = tog & ~bus.MUTE;
  assign bus.BUSY = (state != IDLE);
  assign bus.DONE = done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      hp_cnt <= '0;
      hp_cur <= '0;
      dur    <= '0;
      evt_q  <= '0;
      idx    <= '0;
      tog    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (evt_ok) begin
        state  <= NOTE;
        evt_q  <= bus.EVT;
        idx    <= 2'd0;
        hp_cur <= start_hp;
        hp_cnt <= start_hp - 16'd1;
        dur    <= NOTE_LEN - 24'd1;
        tog    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.COLOR_REQ) begin
            state  <= TONE;
            hp_cur <= hp_of(bus.COLOR);
            hp_cnt <= hp_of(bus.COLOR) - 16'd1;
            dur    <= TONE_LEN - 24'd1;
            tog    <= 1'b0;
          end
          TONE, NOTE: begin
            if (hp_cnt == '0) begin
              tog    <= ~tog;
              hp_cnt <= hp_cur - 16'd1;
            end else begin
              hp_cnt <= hp_cnt - 16'd1;
            end
            if (dur == '0) begin
              tog <= 1'b0;
              // The last note of a melody skips its trailing gap.
              if (state == TONE || idx == 2'd2) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state <= GAP;
                dur   <= GAP_LEN - 24'd1;
              end
            end else begin
              dur <= dur - 24'd1;
            end
          end
          GAP: if (dur == '0) begin
            state  <= NOTE;
            idx    <= idx + 2'd1;
            hp_cur <= next_hp;
            hp_cnt <= next_hp - 16'd1;
            dur    <= NOTE_LEN - 24'd1;
          end else begin
            dur <= dur - 24'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with shortened timing parameters.
module tb_tone_scheduler;
  logic CLK = 1'b0;
  logic RST_N;
  int   n_chk = 0;
  int   n_fail = 0;

  tone_scheduler_if ifc();

  tone_scheduler #(
    .HP0(16'd4), .HP1(16'd3), .HP2(16'd2), .HP3(16'd1),
    .TONE_LEN(24'd20), .NOTE_LEN(24'd16), .GAP_LEN(24'd4)
  ) dut (.CLK(CLK), .RST_N(RST_N), .bus(ifc));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Square wave of half-period hp starting low, len cycles placed at bit off.
  function automatic logic [63:0] wave(input int hp, input int len, input int off);
    logic [63:0] w = '0;
    for (int k = 0; k < len; k++) w[off + k] = ((k / hp) % 2) == 1;
    return w;
  endfunction

  function automatic logic [63:0] melody(input int h0, input int h1, input int h2);
    return wave(h0, 16, 0) | wave(h1, 16, 20) | wave(h2, 16, 40);
  endfunction

  task automatic skip(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_color(input logic [1:0] c);
    ifc.COLOR_REQ = 1'b1; ifc.COLOR = c;
    @(negedge CLK);
    ifc.COLOR_REQ = 1'b0;
  endtask

  task automatic pulse_evt(input logic [1:0] e);
    ifc.EVT_REQ = 1'b1; ifc.EVT = e;
    @(negedge CLK);
    ifc.EVT_REQ = 1'b0;
  endtask

  task automatic cap(input int n, output logic [63:0] w, output int nb, output int nd);
    w = '0; nb = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      w[i] = ifc.SPK;
      nb += int'(ifc.BUSY);
      nd += int'(ifc.DONE);
      @(negedge CLK);
    end
  endtask

  task automatic chk_end(input string tag);
    chk({tag, "_done"}, 64'(ifc.DONE), 64'd1);
    chk({tag, "_idle"}, 64'(ifc.BUSY), 64'd0);
    chk({tag, "_spk"},  64'(ifc.SPK),  64'd0);
  endtask

  initial begin
    logic [63:0] w, e;
    int nb, nd;
    ifc.COLOR_REQ = 1'b0; ifc.COLOR = 2'd0;
    ifc.EVT_REQ = 1'b0;   ifc.EVT = 2'd0;
    ifc.MUTE = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("rst_spk",  64'(ifc.SPK),  64'd0);
    chk("rst_busy", 64'(ifc.BUSY), 64'd0);
    chk("rst_done", 64'(ifc.DONE), 64'd0);
    skip(2);
    RST_N = 1'b1;
    skip(2);

    // Color 0 tone: period 8 for 20 cycles
    pulse_color(2'd0);
    cap(20, w, nb, nd);
    chk("c0_wave", w, wave(4, 20, 0));
    chk("c0_busy", 64'(nb), 64'd20);
    chk("c0_nodone", 64'(nd), 64'd0);
    chk_end("c0");
    skip(1);
    chk("c0_done_1cyc", 64'(ifc.DONE), 64'd0);
    skip(2);

    // Lose melody: periods 2,6,8
    pulse_evt(2'd3);
    cap(56, w, nb, nd);
    chk("lose_wave", w, melody(1, 3, 4));
    chk("lose_busy", 64'(nb), 64'd56);
    chk("lose_nodone", 64'(nd), 64'd0);
    chk_end("lose");
    skip(3);

    // Simultaneous color + start event: event wins
    ifc.COLOR_REQ = 1'b1; ifc.COLOR = 2'd3;
    pulse_evt(2'd0);
    ifc.COLOR_REQ = 1'b0;
    cap(56, w, nb, nd);
    chk("both_wave", w, melody(4, 3, 2));
    chk("both_busy", 64'(nb), 64'd56);
    chk_end("both");
    skip(1);
    chk("both_no_tone", 64'(ifc.BUSY), 64'd0);
    skip(2);

    // Win melody preempted: low class ignored, lose accepted
    pulse_evt(2'd2);
    skip(21);
    pulse_evt(2'd1);
    chk("win_ignore_lo", 64'(ifc.SPK), 64'd1);
    chk("win_no_done", 64'(ifc.DONE), 64'd0);
    pulse_evt(2'd3);
    cap(56, w, nb, nd);
    chk("pre_wave", w, melody(1, 3, 4));
    chk("pre_nodone", 64'(nd), 64'd0);
    chk_end("pre");
    skip(3);

    // Tone: color ignored while busy, event aborts it
    pulse_color(2'd0);
    skip(4);
    pulse_color(2'd3);
    chk("tone_ignore_c", 64'(ifc.SPK), 64'd1);
    skip(3);
    chk("tone_busy", 64'(ifc.BUSY), 64'd1);
    pulse_evt(2'd0);
    cap(56, w, nb, nd);
    chk("abort_wave", w, melody(4, 3, 2));
    chk("abort_nodone", 64'(nd), 64'd0);
    chk_end("abort");
    skip(3);

    // Mute 10 cycles mid-tone
    pulse_color(2'd1);
    w = '0; nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      ifc.MUTE = (i >= 5 && i < 15);
      #1;
      w[i] = ifc.SPK;
      nb += int'(ifc.BUSY);
      nd += int'(ifc.DONE);
      @(negedge CLK);
    end
    ifc.MUTE = 1'b0;
    e = wave(3, 20, 0) & ~(64'h3FF << 5);
    chk("mute_wave", w, e);
    chk("mute_busy", 64'(nb), 64'd20);
    chk_end("mute");
    skip(3);

    // Asynchronous reset mid-melody
    pulse_evt(2'd2);
    skip(4);
    chk("prerst_spk", 64'(ifc.SPK), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_spk",  64'(ifc.SPK),  64'd0);
    chk("arst_busy", 64'(ifc.BUSY), 64'd0);
    chk("arst_done", 64'(ifc.DONE), 64'd0);
    skip(2);
    RST_N = 1'b1;
    cap(60, w, nb, nd);
    chk("post_rst_busy", 64'(nb), 64'd0);
    chk("post_rst_done", 64'(nd), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
- Owns the game's single piezo speaker and arbitrates between two requesters: per-color button/display tones and multi-note event melodies (start, round-clear, win, lose).
- Sits between the game controller and the speaker pin; the controller fires one-cycle requests and never drives audio directly.
- Contains the arbiter/sequencer FSM, note/gap duration counters, a fixed melody ROM and a square-wave divider.

Parameters:
HP0, 16'd4000, half-period in CLK cycles of color-0 tone (also note index 0)
HP1, 16'd3000, half-period of color-1 tone / note 1
HP2, 16'd2400, half-period of color-2 tone / note 2
HP3, 16'd2000, half-period of color-3 tone / note 3
TONE_LEN, 24'd3000000, cycles a color tone sounds
NOTE_LEN, 24'd1500000, cycles per melody note
GAP_LEN, 24'd300000, silent cycles between melody notes

Ports:
CLK  input  1  clock
RST_N  input  1  reset, asynchronous, active-low
COLOR_REQ  input  1  one-cycle request for a color tone
COLOR  input  2  color index, sampled with COLOR_REQ
EVT_REQ  input  1  one-cycle request for an event melody
EVT  input  2  event code, sampled with EVT_REQ: 0 start, 1 round, 2 win, 3 lose
MUTE  input  1  level; forces SPK low, timing unaffected
SPK  output  1  square-wave speaker drive
BUSY  output  1  high while any tone or melody is active
DONE  output  1  one-cycle pulse when a tone/melody completes naturally

Behaviour:
- Reset: SPK=0, BUSY=0, DONE=0, FSM=IDLE, all counters 0. Reset mid-operation aborts immediately, no DONE.
- States: IDLE, TONE, NOTE, GAP. BUSY=1 in every state except IDLE (registered, same cycle as state).
- Melody ROM, 3 notes each, played in order: start 0,1,2; round 2,3,3; win 0,2,3; lose 3,1,0.
- Priority: events 2/3 (class HIGH) > events 0/1 (class LOW) > color.
- IDLE: request sampled at edge N -> state TONE (COLOR) or NOTE note 0 (EVT) from edge N+1. Both requests in the same cycle: event accepted, color dropped.
- Entering TONE or NOTE: SPK=0, half-period counter loaded with HP[idx]-1, duration counter loaded with TONE_LEN-1 / NOTE_LEN-1.
- Square wave: SPK toggles when half-period counter hits 0, counter reloads HP[idx]-1. Period = 2*HP cycles.
- TONE: after exactly TONE_LEN cycles in state -> IDLE, SPK=0, DONE=1 for the first IDLE cycle.
- NOTE: after NOTE_LEN cycles -> GAP (SPK=0, silent). GAP: after GAP_LEN cycles -> NOTE of next index. After the third NOTE, skip GAP -> IDLE with DONE pulse.
- COLOR_REQ while BUSY: ignored, no state change.
- EVT_REQ during TONE: tone aborted (no DONE), melody starts note 0 next cycle.
- EVT_REQ during NOTE/GAP: accepted only if new class >= current class; restarts at note 0 of the new event, no DONE for the aborted one. Otherwise ignored.
- Request coincident with completion cycle: treated as arriving in the active state (completion wins, DONE pulses, request evaluated by the above rules is then lost if ignored; if accepted, no DONE).
- MUTE: SPK=0 while high; internal toggle state keeps running, so SPK resumes mid-phase when released.
- Counters are wide enough for parameters; HPx = 0 is illegal.

Test Plan:
- Params HP0..3=4,3,2,1, TONE_LEN=20, NOTE_LEN=16, GAP_LEN=4. COLOR_REQ, COLOR=0 -> BUSY next cycle, SPK period 8 for 20 cycles, then DONE pulse and BUSY=0.
- EVT_REQ EVT=3 in IDLE -> notes with periods 2,6,8 (16 cycles each) separated by 4 silent cycles, total 56 BUSY cycles, single DONE.
- COLOR_REQ and EVT_REQ=0 same cycle -> start melody (periods 8,6,4), no color tone.
- During win melody note 1, EVT_REQ EVT=1 -> ignored; EVT_REQ EVT=3 -> lose melody restarts from note 0, exactly one DONE at the end.
- Color tone running, COLOR_REQ COLOR=3 at cycle 5 -> ignored; EVT_REQ=0 at cycle 10 -> tone aborts, no DONE, start melody begins.
- MUTE held 10 cycles mid-tone -> SPK=0, BUSY stays 1, total duration unchanged; RST_N low mid-melody -> SPK=0, BUSY=0, DONE=0 asynchronously.
